// File: rtl/aes_block_sequencer.sv
// Multi-block AES front end: input FIFO, ECB/CBC chaining,
// one block in flight to the core, valid/ready ciphertext port.
module aes_block_sequencer #(
  parameter int BLOCK_W = 128,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               AES_clk,
  input  logic               AES_rst_n,
  input  logic               cfg_start,
  input  logic               cfg_mode,
  input  logic [CNT_W-1:0]   cfg_nblocks,
  input  logic [BLOCK_W-1:0] cfg_key,
  input  logic [BLOCK_W-1:0] cfg_iv,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               core_en,
  output logic [BLOCK_W-1:0] core_data_in,
  output logic [BLOCK_W-1:0] core_key_in,
  input  logic               core_data_out_valid,
  input  logic [BLOCK_W-1:0] core_data_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_OUT, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [BLOCK_W-1:0] mem_q [DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic               push, pop, empty, full;

  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   nblk_q, nblk_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic [BLOCK_W-1:0] chain_q, chain_d;
  logic [BLOCK_W-1:0] din_q, din_d;
  logic [BLOCK_W-1:0] dout_q, dout_d;
  logic               last_q, last_d;
  logic               core_en_q, core_en_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign empty    = wr_ptr_q == rd_ptr_q;
  assign full     = (wr_ptr_q - rd_ptr_q) == (AW+1)'(DEPTH);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  always_ff @(posedge AES_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    nblk_d    = nblk_q;
    blk_cnt_d = blk_cnt_q;
    key_d     = key_q;
    chain_d   = chain_q;
    din_d     = din_q;
    dout_d    = dout_q;
    last_d    = last_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          mode_d    = cfg_mode;
          nblk_d    = cfg_nblocks;
          key_d     = cfg_key;
          chain_d   = cfg_iv;
          blk_cnt_d = '0;
          state_d   = (cfg_nblocks == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (!empty) begin
          pop     = 1'b1;
          din_d   = mem_q[rd_ptr_q[AW-1:0]]
                  ^ (mode_q ? chain_q : '0);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (core_data_out_valid) begin
          dout_d  = core_data_out;
          if (mode_q) chain_d = core_data_out;
          last_d  = blk_cnt_q == (nblk_q - CNT_W'(1));
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          blk_cnt_d = blk_cnt_q + CNT_W'(1);
          state_d   = last_q ? S_DONE : S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
    core_en_d   = state_d == S_ISSUE;
    out_valid_d = state_d == S_OUT;
    done_d      = state_d == S_DONE;
    busy_d      = state_d != S_IDLE;
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mode_q      <= 1'b0;
      nblk_q      <= '0;
      blk_cnt_q   <= '0;
      key_q       <= '0;
      chain_q     <= '0;
      din_q       <= '0;
      dout_q      <= '0;
      last_q      <= 1'b0;
      core_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mode_q      <= mode_d;
      nblk_q      <= nblk_d;
      blk_cnt_q   <= blk_cnt_d;
      key_q       <= key_d;
      chain_q     <= chain_d;
      din_q       <= din_d;
      dout_q      <= dout_d;
      last_q      <= last_d;
      core_en_q   <= core_en_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign core_en      = core_en_q;
  assign core_data_in = din_q;
  assign core_key_in  = key_q;
  assign out_valid    = out_valid_q;
  assign out_data     = dout_q;
  assign out_last     = last_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: doc/aes_block_sequencer.md
# aes_block_sequencer

Parametrised multi-block front end for the AES_top encryption core. It buffers host plaintext blocks in an input FIFO and feeds them one at a time to the core with a shared key. In CBC mode it chains each block with the previous ciphertext or the IV; ciphertext is returned on a valid/ready output port with a last-block flag. It sits between the host data path and AES_top and replaces hand-sequenced AES_en/AES_data_in driving.

## Interface
- BLOCK_W, 128, block/key width; must equal the AES_top data width.
- DEPTH, 4, input FIFO depth in blocks; power of two, ≥2.
- CNT_W, 16, width of the block-count field.

- AES_clk  in  1  clock, rising edge.
- AES_rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- cfg_start  in  1  one-cycle pulse that starts a message; sampled only in IDLE.
- cfg_mode  in  1  0 = ECB, 1 = CBC; captured at start.
- cfg_nblocks  in  CNT_W  blocks in the message; captured at start.
- cfg_key  in  BLOCK_W  key; captured at start.
- cfg_iv  in  BLOCK_W  CBC IV; captured at start.
- in_valid / in_ready / in_data  in / out / in  1 / 1 / BLOCK_W  plaintext push port.
- core_en  out  1  one-cycle issue pulse to AES_en.
- core_data_in  out  BLOCK_W  to AES_data_in.
- core_key_in  out  BLOCK_W  to AES_key_in.
- core_data_out_valid  in  1  from AES_data_out_valid.
- core_data_out  in  BLOCK_W  from AES_data_out.
- out_valid / out_ready / out_data / out_last  out / in / out / out  1 / 1 / BLOCK_W / 1  ciphertext port.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse at message end.

## Operation
- Core contract: each core_en pulse yields exactly one core_data_out_valid pulse, after any number of cycles. At most one block is in flight.
- Input FIFO:
  - in_ready = !full. A push happens on in_valid && in_ready and is accepted in any state, so the host can preload before start.
  - Push and pop in the same cycle are legal.
  - When full, in_ready stays low even if a pop occurs that cycle.
- States:
  - IDLE: on cfg_start, capture cfg_*, clear blk_cnt, set chain = cfg_iv. Go to LOAD, or to DONE if cfg_nblocks == 0.
  - LOAD: wait for the FIFO to be non-empty. Then pop the head and register core_data_in = head ^ chain (CBC) or head (ECB). Go to ISSUE.
  - ISSUE: core_en = 1 for this cycle only. Go to WAIT.
  - WAIT: on core_data_out_valid, register out_data = core_data_out. In CBC, set chain = core_data_out. Set out_last = (blk_cnt == nblocks−1). Go to OUT.
  - OUT: hold out_valid = 1 with out_data and out_last stable until out_ready. On handshake, blk_cnt++, then go to DONE if out_last, else LOAD.
  - DONE: done = 1 for one cycle. Go to IDLE.
- core_key_in drives the captured key continuously from start to the next start.
- core_data_out_valid outside WAIT is ignored.
- cfg_start outside IDLE is ignored; captured config does not change.
- blk_cnt is CNT_W bits. nblocks up to 2^CNT_W−1 is supported with no wrap.
- Leftover FIFO contents after DONE are kept and used by the next message.
- Reset (async, mid-operation included): state = IDLE, FIFO emptied, blk_cnt = 0, chain = 0. Any in-flight core result is dropped.

## Timing
- Reset values: core_en = 0, core_data_in = 0, core_key_in = 0, out_valid = 0, out_data = 0, out_last = 0, busy = 0, done = 0, in_ready = 1 (after reset release).
- With a preloaded FIFO, cfg_start at cycle t gives: LOAD at t+1, core_en at t+2, WAIT from t+3.
- core_data_out_valid at cycle c gives out_valid at c+1.
- An out_ready handshake at cycle h gives core_en for the next block at h+2 if the FIFO is non-empty, otherwise later.
- For the last block, a handshake at h gives done at h+1 and busy low at h+2.
- cfg_nblocks == 0: done at t+1, no core_en.
- All outputs are registered; no combinational path from inputs to outputs except in_ready from FIFO state.

## Test plan
- ECB, 1 block: key 000102030405060708090a0b0c0d0e0f, in 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_last = 1, done one cycle later, one core_en total.
- CBC, 2 blocks:
  - Setup: key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f.
  - P1 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d.
  - P2 ae2d8a571e03ac9c9eb76fac45af8e51 -> 5086cb9b507219ee95db113a917678b2, last = 1.
- Backpressure and FIFO full:
  - Preload DEPTH blocks, check in_ready = 0 with the FIFO full.
  - Run 6 blocks with out_ready held low 20 cycles on block 2.
  - Require out_data stable while stalled, no extra core_en, and FIFO order preserved.
- Zero-length message: cfg_nblocks = 0 -> done at t+1, core_en never asserted, FIFO untouched.
- Start while busy: pulse cfg_start mid-message with a different key -> ignored; ciphertext still matches the original key.
- Reset in WAIT: assert AES_rst_n low before core_data_out_valid -> all outputs at reset values, FIFO empty, and a late core valid after release produces no out_valid.
